// File: rtl/req_sched_pkg.sv
// req_sched_pkg: shared types and defaults for the two-channel request scheduler.
//   chan_state_t  - per-channel FSM state, 2-bit encoding (IDLE, REQ, SERVE, REL)
//   CNT_W_DEF     - default pending-counter width
//   HOLD_CYC_DEF  - default grant hold time in cycles
//   TIMEOUT_DEF   - default REQ wait limit (used only with REQ_SCHED_TIMEOUT_EN)
//   HOLD_W        - hold-counter width (HOLD_CYC is limited to 1..255)
package req_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SERVE = 2'd2,
    ST_REL   = 2'd3
  } chan_state_t;

  localparam int CNT_W_DEF    = 4;
  localparam int HOLD_CYC_DEF = 3;
  localparam int TIMEOUT_DEF  = 16;
  localparam int HOLD_W       = 8;

endpackage

// File: rtl/req_sched_if.sv
// req_sched_if: signal bundle between the job source / arbiter side and the
// scheduler.
//   job_x  : one-cycle job-arrival pulse for channel x
//   gnt_x  : grant from the arbiter for channel x
//   req_x  : registered request to the arbiter for channel x
//   pend_x : pending job count, done_x : job-serviced pulse
//   ovf_x  : sticky overflow, tmo_x : sticky request timeout
// Handshake: req_x/gnt_x follow request/grant semantics. The scheduler raises
// req_x and keeps it high until it has held gnt_x for HOLD_CYC cycles; it then
// lowers req_x for at least one cycle and waits for gnt_x to fall before it
// may request again. A grant that falls early returns the channel to
// requesting without consuming the job.
// Modports: master = job source + arbiter side, slave = scheduler.
interface req_sched_if #(
  parameter int CNT_W = 4
);
  logic             job_0;
  logic             job_1;
  logic             gnt_0;
  logic             gnt_1;
  logic             req_0;
  logic             req_1;
  logic [CNT_W-1:0] pend_0;
  logic [CNT_W-1:0] pend_1;
  logic             done_0;
  logic             done_1;
  logic             ovf_0;
  logic             ovf_1;
  logic             tmo_0;
  logic             tmo_1;

  modport master (
    output job_0, job_1, gnt_0, gnt_1,
    input  req_0, req_1, pend_0, pend_1, done_0, done_1,
           ovf_0, ovf_1, tmo_0, tmo_1
  );

  modport slave (
    input  job_0, job_1, gnt_0, gnt_1,
    output req_0, req_1, pend_0, pend_1, done_0, done_1,
           ovf_0, ovf_1, tmo_0, tmo_1
  );
endinterface

// File: rtl/req_sched_chan.sv
// req_sched_chan: one scheduler channel - FSM, pending counter, hold counter,
// overflow flag and (optional) request timeout.
// Optional feature macro: REQ_SCHED_TIMEOUT_EN (wait counter + sticky tmo).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   i_job       - job-arrival pulse
//   i_gnt       - grant from arbiter
//   o_req       - registered request to arbiter
//   o_pend      - pending job count (saturating)
//   o_done      - one-cycle pulse when a job finishes its hold time
//   o_ovf       - sticky: job dropped while the counter was saturated
//   o_tmo       - sticky: request waited TIMEOUT cycles (0 when feature off)
//   o_state     - current FSM state (debug)
module req_sched_chan
  import req_sched_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_job,
  input  logic             i_gnt,
  output logic             o_req,
  output logic [CNT_W-1:0] o_pend,
  output logic             o_done,
  output logic             o_ovf,
  output logic             o_tmo,
  output chan_state_t      o_state
);

  localparam logic [CNT_W-1:0]  PEND_MAX  = '1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  chan_state_t       r_state;
  logic [CNT_W-1:0]  r_pend;
  logic [HOLD_W-1:0] r_hold;
  logic              r_req;
  logic              r_done;
  logic              r_ovf;

  logic             w_last;
  logic             w_dec;
  logic             w_drop;
  logic [CNT_W-1:0] w_pend_nxt;

  assign w_last = (r_hold == HOLD_LAST);
  // A job completes only on the last hold cycle with the grant still present.
  assign w_dec  = (r_state == ST_SERVE) && i_gnt && w_last;
  // An arrival that coincides with a completion cancels out, so it can never
  // be dropped even when the counter is full.
  assign w_drop = i_job && !w_dec && (r_pend == PEND_MAX);

  always_comb begin
    w_pend_nxt = r_pend;
    if (i_job && !w_dec) begin
      if (r_pend != PEND_MAX) w_pend_nxt = r_pend + 1'b1;
    end else if (!i_job && w_dec) begin
      w_pend_nxt = r_pend - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_hold  <= '0;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_done <= w_dec;
      if (w_drop) r_ovf <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if ((r_pend != '0) || i_job) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (i_gnt) begin
            r_state <= ST_SERVE;
            r_hold  <= '0;
          end
        end
        ST_SERVE: begin
          if (!i_gnt) begin
            // Grant lost before the hold time elapsed: ask again.
            r_state <= ST_REQ;
            r_hold  <= '0;
          end else if (w_last) begin
            r_state <= ST_REL;
            r_req   <= 1'b0;
            r_hold  <= '0;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        ST_REL: begin
          // Entered with req already low, so req stays low at least one cycle.
          if (!i_gnt) begin
            if (w_pend_nxt != '0) begin
              r_state <= ST_REQ;
              r_req   <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

`ifdef REQ_SCHED_TIMEOUT_EN
  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(TIMEOUT);

  logic [WAIT_W-1:0] r_wait;
  logic              r_tmo;

  // Counts cycles spent in REQ; saturates so it never wraps while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
      r_tmo  <= 1'b0;
    end else if (r_state == ST_REQ) begin
      if (r_wait == WAIT_LAST) r_tmo <= 1'b1;
      if (r_wait != WAIT_SAT) r_wait <= r_wait + 1'b1;
    end else begin
      r_wait <= '0;
    end
  end

  assign o_tmo = r_tmo;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign o_tmo = 1'b0;
`endif

  assign o_req   = r_req;
  assign o_pend  = r_pend;
  assign o_done  = r_done;
  assign o_ovf   = r_ovf;
  assign o_state = r_state;

endmodule

// File: rtl/req_sched.sv
// req_sched: two-channel request scheduler feeding a two-requester grant
// arbiter. Each channel queues job pulses, requests the arbiter, holds the
// grant HOLD_CYC cycles, then releases it.
// Optional feature macro: REQ_SCHED_TIMEOUT_EN (per-channel request timeout).
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   io_sched       - req_sched_if.slave: job/gnt in, req/pend/done/ovf/tmo out
//   o_dbg_state_0  - channel 0 FSM state (debug)
//   o_dbg_state_1  - channel 1 FSM state (debug)
module req_sched
  import req_sched_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  req_sched_if.slave    io_sched,
  output chan_state_t   o_dbg_state_0,
  output chan_state_t   o_dbg_state_1
);

  req_sched_chan #(
    .CNT_W   (CNT_W),
    .HOLD_CYC(HOLD_CYC),
    .TIMEOUT (TIMEOUT)
  ) u_chan_0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_job  (io_sched.job_0),
    .i_gnt  (io_sched.gnt_0),
    .o_req  (io_sched.req_0),
    .o_pend (io_sched.pend_0),
    .o_done (io_sched.done_0),
    .o_ovf  (io_sched.ovf_0),
    .o_tmo  (io_sched.tmo_0),
    .o_state(o_dbg_state_0)
  );

  req_sched_chan #(
    .CNT_W   (CNT_W),
    .HOLD_CYC(HOLD_CYC),
    .TIMEOUT (TIMEOUT)
  ) u_chan_1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_job  (io_sched.job_1),
    .i_gnt  (io_sched.gnt_1),
    .o_req  (io_sched.req_1),
    .o_pend (io_sched.pend_1),
    .o_done (io_sched.done_1),
    .o_ovf  (io_sched.ovf_1),
    .o_tmo  (io_sched.tmo_1),
    .o_state(o_dbg_state_1)
  );

endmodule

// File: tb/tb_req_sched.sv
// tb_req_sched: directed self-checking bench for req_sched (CNT_W=4, HOLD_CYC=3,
// TIMEOUT=16). Inputs change 1 time unit after the rising edge and outputs are
// sampled at that same point, well away from the next edge.
module tb_req_sched;
  import req_sched_pkg::*;

`ifdef REQ_SCHED_TIMEOUT_EN
  localparam logic TMO_EXP = 1'b1;
`else
  localparam logic TMO_EXP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  chan_state_t st0;
  chan_state_t st1;
  int          n_total;
  int          n_bad;

  req_sched_if #(.CNT_W(4)) bus ();

  req_sched #(.CNT_W(4), .HOLD_CYC(3), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .io_sched     (bus),
    .o_dbg_state_0(st0),
    .o_dbg_state_1(st1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.job_0 = 1'b0; bus.job_1 = 1'b0;
    bus.gnt_0 = 1'b0; bus.gnt_1 = 1'b0;
    step(); step();
    n_total++;
    if ({bus.req_0, bus.req_1, bus.done_0, bus.done_1, bus.ovf_0, bus.ovf_1,
         bus.tmo_0, bus.tmo_1} !== 8'h00) begin
      n_bad++; $display("FAIL reset_flags: got %b want 00000000",
        {bus.req_0, bus.req_1, bus.done_0, bus.done_1, bus.ovf_0, bus.ovf_1, bus.tmo_0, bus.tmo_1});
    end
    n_total++;
    if ({bus.pend_0, bus.pend_1} !== 8'h00) begin
      n_bad++; $display("FAIL reset_pend: got %h want 00", {bus.pend_0, bus.pend_1});
    end
    n_total++;
    if (st0 !== ST_IDLE || st1 !== ST_IDLE) begin
      n_bad++; $display("FAIL reset_state: got %0d/%0d want 0/0", st0, st1);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_job();
    int lat;
    bus.job_0 = 1'b1;
    step();
    bus.job_0 = 1'b0;
    n_total++;
    if (bus.req_0 !== 1'b1 || bus.pend_0 !== 4'd1) begin
      n_bad++; $display("FAIL single_req_rise: got req=%b pend=%0d want req=1 pend=1", bus.req_0, bus.pend_0);
    end
    bus.gnt_0 = 1'b1;
    step();
    n_total++;
    if (st0 !== ST_SERVE || bus.req_0 !== 1'b1) begin
      n_bad++; $display("FAIL single_serve: got st=%0d req=%b want st=2 req=1", st0, bus.req_0);
    end
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus.done_0 === 1'b1) begin lat = i; break; end
    end
    n_total++;
    if (lat != 3) begin
      n_bad++; $display("FAIL single_latency: got %0d want 3", lat);
    end
    n_total++;
    if (bus.req_0 !== 1'b0 || bus.pend_0 !== 4'd0 || st0 !== ST_REL) begin
      n_bad++; $display("FAIL single_rel: got req=%b pend=%0d st=%0d want req=0 pend=0 st=3",
        bus.req_0, bus.pend_0, st0);
    end
    // grant still high while in REL: must be ignored
    step();
    n_total++;
    if (st0 !== ST_REL || bus.req_0 !== 1'b0 || bus.done_0 !== 1'b0) begin
      n_bad++; $display("FAIL single_rel_hold: got st=%0d req=%b done=%b want st=3 req=0 done=0",
        st0, bus.req_0, bus.done_0);
    end
    bus.gnt_0 = 1'b0;
    step();
    n_total++;
    if (st0 !== ST_IDLE || bus.req_0 !== 1'b0) begin
      n_bad++; $display("FAIL single_idle: got st=%0d req=%b want st=0 req=0", st0, bus.req_0);
    end
  endtask

  task automatic test_back_to_back();
    int         n_done;
    int         bad_rel;
    logic [3:0] pend_max;
    logic [3:0] pend_at_done [3];
    n_done = 0; bad_rel = 0; pend_max = 4'd0;
    for (int k = 0; k < 3; k++) pend_at_done[k] = 4'hF;
    for (int i = 0; i < 40; i++) begin
      bus.job_1 = (i < 3);
      step();
      bus.gnt_1 = bus.req_1;  // arbiter grants one cycle after request
      if (bus.pend_1 > pend_max) pend_max = bus.pend_1;
      if (bus.done_1 === 1'b1) begin
        if (n_done < 3) pend_at_done[n_done] = bus.pend_1;
        n_done++;
        if (bus.req_1 !== 1'b0) bad_rel++;
      end
    end
    bus.job_1 = 1'b0;
    bus.gnt_1 = 1'b0;
    n_total++;
    if (n_done != 3) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 3", n_done); end
    n_total++;
    if (pend_max !== 4'd3) begin n_bad++; $display("FAIL b2b_pend_max: got %0d want 3", pend_max); end
    n_total++;
    if (pend_at_done[0] !== 4'd2 || pend_at_done[1] !== 4'd1 || pend_at_done[2] !== 4'd0) begin
      n_bad++; $display("FAIL b2b_pend_seq: got %0d,%0d,%0d want 2,1,0",
        pend_at_done[0], pend_at_done[1], pend_at_done[2]);
    end
    n_total++;
    if (bad_rel != 0) begin n_bad++; $display("FAIL b2b_release: got %0d req-high dones want 0", bad_rel); end
    n_total++;
    if (st1 !== ST_IDLE || bus.req_1 !== 1'b0) begin
      n_bad++; $display("FAIL b2b_idle: got st=%0d req=%b want st=0 req=0", st1, bus.req_1);
    end
  endtask

  task automatic test_saturate();
    for (int i = 1; i <= 16; i++) begin
      bus.job_0 = 1'b1;
      step();
      if (i == 15) begin
        n_total++;
        if (bus.pend_0 !== 4'd15 || bus.ovf_0 !== 1'b0) begin
          n_bad++; $display("FAIL sat_15: got pend=%0d ovf=%b want pend=15 ovf=0", bus.pend_0, bus.ovf_0);
        end
      end
    end
    bus.job_0 = 1'b0;
    n_total++;
    if (bus.pend_0 !== 4'd15 || bus.ovf_0 !== 1'b1) begin
      n_bad++; $display("FAIL sat_16: got pend=%0d ovf=%b want pend=15 ovf=1", bus.pend_0, bus.ovf_0);
    end
    step(); step(); step();
    n_total++;
    if (bus.pend_0 !== 4'd15 || bus.ovf_0 !== 1'b1 || bus.req_0 !== 1'b1) begin
      n_bad++; $display("FAIL sat_hold: got pend=%0d ovf=%b req=%b want 15/1/1", bus.pend_0, bus.ovf_0, bus.req_0);
    end
    // asynchronous reset in mid-cycle clears everything without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.req_0 !== 1'b0 || bus.pend_0 !== 4'd0 || bus.ovf_0 !== 1'b0 || st0 !== ST_IDLE) begin
      n_bad++; $display("FAIL async_reset: got req=%b pend=%0d ovf=%b st=%0d want 0/0/0/0",
        bus.req_0, bus.pend_0, bus.ovf_0, st0);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_job_on_dec();
    int n_done;
    bus.job_0 = 1'b1;
    step(); step();
    bus.job_0 = 1'b0;
    n_total++;
    if (bus.pend_0 !== 4'd2) begin n_bad++; $display("FAIL dec_pend_pre: got %0d want 2", bus.pend_0); end
    bus.gnt_0 = 1'b1;
    step(); step(); step();
    n_total++;
    if (st0 !== ST_SERVE || bus.done_0 !== 1'b0) begin
      n_bad++; $display("FAIL dec_serve: got st=%0d done=%b want st=2 done=0", st0, bus.done_0);
    end
    bus.job_0 = 1'b1;
    step();
    bus.job_0 = 1'b0;
    n_total++;
    if (bus.pend_0 !== 4'd2 || bus.done_0 !== 1'b1 || st0 !== ST_REL) begin
      n_bad++; $display("FAIL dec_same_cycle: got pend=%0d done=%b st=%0d want 2/1/3",
        bus.pend_0, bus.done_0, st0);
    end
    // drain the two remaining jobs
    n_done = 0;
    bus.gnt_0 = bus.req_0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.done_0 === 1'b1) n_done++;
      bus.gnt_0 = bus.req_0;
    end
    bus.gnt_0 = 1'b0;
    n_total++;
    if (n_done != 2 || bus.pend_0 !== 4'd0 || st0 !== ST_IDLE) begin
      n_bad++; $display("FAIL dec_drain: got done=%0d pend=%0d st=%0d want 2/0/0", n_done, bus.pend_0, st0);
    end
  endtask

  task automatic test_early_drop();
    int lat;
    bus.gnt_1 = 1'b1;  // grant while IDLE: ignored
    step();
    n_total++;
    if (st1 !== ST_IDLE || bus.req_1 !== 1'b0) begin
      n_bad++; $display("FAIL drop_idle_gnt: got st=%0d req=%b want st=0 req=0", st1, bus.req_1);
    end
    bus.gnt_1 = 1'b0;
    bus.job_1 = 1'b1;
    step();
    bus.job_1 = 1'b0;
    bus.gnt_1 = 1'b1;
    step();
    bus.gnt_1 = 1'b0;
    step();
    n_total++;
    if (st1 !== ST_REQ || bus.req_1 !== 1'b1 || bus.pend_1 !== 4'd1 || bus.done_1 !== 1'b0) begin
      n_bad++; $display("FAIL drop_back_to_req: got st=%0d req=%b pend=%0d done=%b want 1/1/1/0",
        st1, bus.req_1, bus.pend_1, bus.done_1);
    end
    bus.gnt_1 = 1'b1;
    step();
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus.done_1 === 1'b1) begin lat = i; break; end
    end
    n_total++;
    if (lat != 3 || bus.pend_1 !== 4'd0) begin
      n_bad++; $display("FAIL drop_full_grant: got lat=%0d pend=%0d want lat=3 pend=0", lat, bus.pend_1);
    end
    bus.gnt_1 = 1'b0;
    step();
    n_total++;
    if (st1 !== ST_IDLE) begin n_bad++; $display("FAIL drop_idle: got %0d want 0", st1); end
  endtask

  task automatic test_timeout();
    bus.job_0 = 1'b1;
    step();
    bus.job_0 = 1'b0;
    for (int i = 0; i < 15; i++) step();
    n_total++;
    if (bus.tmo_0 !== 1'b0 || bus.req_0 !== 1'b1) begin
      n_bad++; $display("FAIL tmo_before: got tmo=%b req=%b want tmo=0 req=1", bus.tmo_0, bus.req_0);
    end
    step();
    n_total++;
    if (bus.tmo_0 !== TMO_EXP || st0 !== ST_REQ) begin
      n_bad++; $display("FAIL tmo_reach: got tmo=%b st=%0d want tmo=%b st=1", bus.tmo_0, st0, TMO_EXP);
    end
    bus.gnt_0 = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_total++;
    if (bus.tmo_0 !== TMO_EXP || bus.done_0 !== 1'b1) begin
      n_bad++; $display("FAIL tmo_sticky: got tmo=%b done=%b want tmo=%b done=1", bus.tmo_0, bus.done_0, TMO_EXP);
    end
    bus.gnt_0 = 1'b0;
    step();
    n_total++;
    if (st0 !== ST_IDLE || bus.tmo_1 !== 1'b0) begin
      n_bad++; $display("FAIL tmo_end: got st=%0d tmo_1=%b want 0/0", st0, bus.tmo_1);
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    test_reset();
    test_single_job();
    test_back_to_back();
    test_saturate();
    test_job_on_dec();
    test_early_drop();
    test_timeout();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/req_sched.md
Name: req_sched

Overview:
- Two-channel request scheduler placed directly upstream of the two-requester grant arbiter.
- Accepts job-arrival pulses per channel, queues them as pending counts, and drives the arbiter's req_0/req_1.
- Holds each grant for a fixed service time, then drops the request so the arbiter returns to IDLE.
- Reports job completion, pending depth and overflow per channel.

Parameters:
- CNT_W, 4, width of each channel's pending-job counter; saturates at 2**CNT_W-1.
- HOLD_CYC, 3, cycles a grant is held per job (1..255).
- TIMEOUT, 16, max cycles in REQ before timeout flag (only with REQ_SCHED_TIMEOUT_EN).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- job_0  in  1  one-cycle pulse, new job for channel 0.
- job_1  in  1  one-cycle pulse, new job for channel 1.
- gnt_0  in  1  grant from arbiter, channel 0.
- gnt_1  in  1  grant from arbiter, channel 1.
- req_0  out  1  request to arbiter, channel 0 (registered).
- req_1  out  1  request to arbiter, channel 1 (registered).
- pend_0  out  CNT_W  pending jobs, channel 0.
- pend_1  out  CNT_W  pending jobs, channel 1.
- done_0  out  1  one-cycle pulse, channel 0 job serviced.
- done_1  out  1  one-cycle pulse, channel 1 job serviced.
- ovf_0  out  1  sticky: channel 0 job dropped at saturation.
- ovf_1  out  1  sticky: channel 1 job dropped at saturation.
- tmo_0  out  1  sticky: channel 0 request timed out.
- tmo_1  out  1  sticky: channel 1 request timed out.

Behaviour:
- Reset: all outputs 0, pend = 0, both channels in IDLE, hold counters 0.
- Reset is asynchronous and active-low. Asserting it mid-operation drops req immediately; queued jobs are lost.
- The two channels are independent, identical FSMs. States: IDLE, REQ, SERVE, REL.
- IDLE -> REQ when pend != 0 or job_x = 1. req_x is high the cycle after job_x is sampled.
- REQ: req_x = 1. On gnt_x = 1 -> SERVE, hold counter cleared.
- SERVE: req_x = 1, hold counter increments each cycle.
  - When the counter reaches HOLD_CYC-1 -> REL, pend decrements, done_x pulses for 1 cycle.
  - If gnt_x drops early -> REQ; no decrement, hold counter cleared.
- REL: req_x = 0. Wait for gnt_x = 0, then -> REQ if pend != 0, else IDLE.
  - req_x stays low for at least 1 cycle so the arbiter observes the release.
- Grant-to-done latency is exactly HOLD_CYC cycles.
- Counter update rules:
  - job_x on the same cycle as the decrement: pend unchanged.
  - job_x at pend = max with no decrement: job dropped, pend held, ovf_x set (sticky until reset).
- gnt_x while in IDLE or REL-awaiting-drop: ignored; no state change.
- Simultaneous job_0 and job_1: both accepted independently. Arbitration between channels is the arbiter's job.

Optional Feature:
- Macro: REQ_SCHED_TIMEOUT_EN.
- Defined: a per-channel wait counter runs while in REQ and clears on leaving REQ.
  - Reaching TIMEOUT cycles sets tmo_x (sticky until reset).
  - The FSM keeps requesting; no state change.
- Undefined: no wait counter is built, tmo_0 and tmo_1 are tied to 0, and TIMEOUT is unused.

Decomposition:
- Package req_sched_pkg holds:
  - the channel state typedef (IDLE, REQ, SERVE, REL) with a 2-bit encoding;
  - the CNT_W and HOLD_CYC defaults;
  - a hold-counter width constant (8 bits).
- Sub-module req_sched_chan contains one channel's FSM, pending counter, hold counter, ovf flag and optional timeout logic.
- req_sched instantiates req_sched_chan twice.

Test Plan:
- Reset release, one job_0 pulse, gnt_0 returned 1 cycle after req_0 rises -> req_0 high the cycle after job_0; done_0 pulses 3 cycles after gnt_0 rises; req_0 low in REL; pend_0 goes 1 -> 0; FSM returns to IDLE.
- 3 job_1 pulses back to back, arbiter model grants in turn -> pend_1 = 3, then 2, 1, 0 over three SERVE/REL cycles; exactly 3 done_1 pulses; req_1 low for at least 1 cycle between each.
- 16 job_0 pulses with no grants (CNT_W = 4) -> pend_0 saturates at 15; ovf_0 = 1 from the 16th pulse; pend_0 stays at 15.
- job_0 on the same cycle as the SERVE -> REL decrement with pend_0 = 2 -> pend_0 stays 2; done_0 pulses once.
- gnt_1 dropped after 1 SERVE cycle -> FSM back to REQ; no done_1; pend_1 unchanged; a later full grant completes normally.
- With REQ_SCHED_TIMEOUT_EN and TIMEOUT = 16, req_0 held 16 cycles ungranted -> tmo_0 = 1 and stays 1 after the grant. Without the macro -> tmo_0 stays 0.
